// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with byte FIFO
// Purpose: CPU stores to TXDATA (BASE+0) queue bytes in a FIFO; a serializer
//   drains the FIFO onto tx as 8N1 frames. STATUS (BASE+4) is read combinationally.
// Ports:
//   clk          system clock, all state on rising edge
//   rst_n        synchronous active-low reset
//   data_addr    CPU data address
//   data_wr      CPU store data
//   data_wr_en   CPU byte write enables (only bit 0 is used)
//   data_rd_out  STATUS read data; 0 for TXDATA or when hit=0
//   hit          data_addr falls in this block's 8-byte window
//   tx           serial output, registered, idle high
//   busy         FIFO non-empty or frame in progress
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr,
  input  logic [3:0]  data_wr_en,
  output logic [31:0] data_rd_out,
  output logic        hit,
  output logic        tx,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state_q, state_d;
  logic          tx_q, tx_d;
  logic [7:0]    shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic          pop;
  logic          cnt_end;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          ovf;
  logic          empty, full, idle;
  logic          sel_tx, sel_st, push, ovf_set, ovf_clr;
  logic [7:0]    head;

  // Upper write enables and low store-data bits have no register behind them.
  logic unused_bits;
  assign unused_bits = ^{data_addr[1:0], data_wr[31:3], data_wr[1:0], data_wr_en[3:1]};

  assign hit     = (data_addr[31:3] == BASE_ADDR[31:3]);
  assign sel_tx  = hit & ~data_addr[2] & data_wr_en[0];
  assign sel_st  = hit &  data_addr[2] & data_wr_en[0];
  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign idle    = (state_q == S_IDLE) & empty;
  assign head    = fifo_mem[rd_ptr];
  // A pop frees a slot in the same cycle, so a full FIFO still accepts then.
  assign push    = sel_tx & (~full | pop);
  assign ovf_set = sel_tx & full & ~pop;
  assign ovf_clr = sel_st & data_wr[2];
  assign cnt_end = (cnt_q == CNT_LAST);

  assign tx   = tx_q;
  assign busy = ~idle;
  assign data_rd_out = (hit & data_addr[2]) ?
                       {16'h0, 8'(count), 4'h0, empty, ovf, full, idle} : 32'h0;

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    pop     = 1'b0;
    if (state_q != S_IDLE) cnt_d = cnt_end ? '0 : cnt_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          tx_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_end) begin
          tx_d    = shift_q[0];
          bit_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_end) begin
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            // Next bit is shift_q[1], i.e. bit 0 of the shifted value.
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (cnt_end) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tx_q    <= 1'b1;
      shift_q <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (ovf_clr)      ovf <= 1'b0;
      else if (ovf_set) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) fifo_mem[wr_ptr] <= data_wr[7:0];
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx
module tb_mmio_uart_tx;

  localparam int          CD   = 4;
  localparam int          DEP  = 4;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] data_addr;
  logic [31:0] data_wr;
  logic [3:0]  data_wr_en;
  logic [31:0] data_rd_out;
  logic        hit;
  logic        tx;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue of waiting bytes plus the frame on the wire,
  // described by its start edge and byte value.
  logic [7:0] mq[$];
  bit         m_active = 0;
  int         m_start  = 0;
  logic [7:0] m_byte   = 8'h0;
  bit         m_ovf    = 0;
  int         k        = 0;

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLK_DIV(CD), .FIFO_DEPTH(DEP)) dut (
    .clk(clk), .rst_n(rst_n), .data_addr(data_addr), .data_wr(data_wr),
    .data_wr_en(data_wr_en), .data_rd_out(data_rd_out), .hit(hit),
    .tx(tx), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic model_tx();
    int idx;
    if (!m_active) return 1'b1;
    idx = (k - m_start) / CD;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_byte[idx-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_status();
    logic e, f, i;
    e = (mq.size() == 0);
    f = (mq.size() == DEP);
    i = !m_active && e;
    return {16'h0, 8'(mq.size()), 4'h0, e, 1'(m_ovf), f, i};
  endfunction

  // One clock cycle: drive the bus, check combinational outputs, clock,
  // advance the model, check registered outputs.
  task automatic step(input logic rn, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be);
    logic mhit, preq, clr, do_pop;
    rst_n = rn; data_addr = a; data_wr = d; data_wr_en = be;
    #1;
    mhit = (a[31:3] == BASE[31:3]);
    chk("hit", {31'h0, hit}, {31'h0, mhit});
    chk("rd_out", data_rd_out, (mhit && a[2]) ? model_status() : 32'h0);
    @(posedge clk);
    k++;
    if (!rn) begin
      mq.delete();
      m_active = 0;
      m_ovf    = 0;
    end else begin
      preq   = mhit && !a[2] && be[0];
      clr    = mhit && a[2] && be[0] && d[2];
      do_pop = 0;
      if (!m_active) do_pop = (mq.size() > 0);
      else if (k - m_start == 10*CD) begin
        if (mq.size() > 0) do_pop = 1;
        else m_active = 0;
      end
      if (do_pop) begin
        m_byte   = mq.pop_front();
        m_active = 1;
        m_start  = k;
      end
      if (preq) begin
        if (mq.size() < DEP) mq.push_back(d[7:0]);
        else m_ovf = 1;
      end
      if (clr) m_ovf = 0;
    end
    #1;
    chk("tx", {31'h0, tx}, {31'h0, model_tx()});
    chk("busy", {31'h0, busy}, {31'h0, (m_active || mq.size() > 0)});
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic peek_status(input string tag, input logic [31:0] expv);
    data_addr = BASE + 32'h4; data_wr_en = 4'h0;
    #1;
    chk(tag, data_rd_out, expv);
  endtask

  initial begin
    rst_n = 1'b0; data_addr = 32'h0; data_wr = 32'h0; data_wr_en = 4'h0;

    // 1: reset
    step(1'b0, 32'h0, 32'h0, 4'h0);
    step(1'b0, 32'h0, 32'h0, 4'h0);
    chk("reset_tx", {31'h0, tx}, 32'h1);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    peek_status("reset_status", 32'h0000_0009);

    // 2: single byte 0x55
    step(1'b1, BASE, 32'h55, 4'h1);
    idle_cycles(45);
    peek_status("single_done", 32'h0000_0009);

    // 3: six consecutive stores into a 4-deep FIFO
    for (int i = 0; i < 6; i++) step(1'b1, BASE, 32'hA0 + i, 4'h1);
    peek_status("burst_full_ovf", 32'h0000_0406);
    idle_cycles(200);
    peek_status("burst_drained", 32'h0000_000D);

    // 4: overflow clear only with data bit 2 set
    step(1'b1, BASE + 32'h4, 32'hFFFF_FFFB, 4'h1);
    peek_status("ovf_kept", 32'h0000_000D);
    step(1'b1, BASE + 32'h4, 32'h4, 4'h1);
    peek_status("ovf_cleared", 32'h0000_0009);

    // 5: ignored enables and out-of-window store
    step(1'b1, BASE, 32'h77, 4'b1110);
    peek_status("be_ignored", 32'h0000_0009);
    step(1'b1, 32'h2000_0000, 32'h77, 4'h1);
    data_addr = 32'h2000_0004;
    #1;
    chk("miss_hit", {31'h0, hit}, 32'h0);
    chk("miss_rd", data_rd_out, 32'h0);
    peek_status("miss_status", 32'h0000_0009);

    // 6: reset during DATA bit 3 with bytes still queued
    step(1'b1, BASE, 32'hC3, 4'h1);
    step(1'b1, BASE, 32'h3C, 4'h1);
    step(1'b1, BASE, 32'h81, 4'h1);
    idle_cycles(15);
    step(1'b0, 32'h0, 32'h0, 4'h0);
    chk("midreset_tx", {31'h0, tx}, 32'h1);
    peek_status("midreset_status", 32'h0000_0009);
    idle_cycles(60);

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      int op;
      op = int'($urandom_range(0, 19));
      if (op < 9)       step(1'b1, BASE, $urandom, 4'($urandom_range(0, 15)) | 4'h1);
      else if (op < 11) step(1'b1, BASE, $urandom, 4'($urandom_range(0, 15)));
      else if (op < 13) step(1'b1, BASE + 32'h4, 32'h0, 4'h0);
      else if (op < 14) step(1'b1, BASE + 32'h4, $urandom, 4'h1);
      else if (op < 16) step(1'b1, $urandom, $urandom, 4'($urandom_range(0, 15)));
      else if (op < 19) step(1'b1, 32'h0, 32'h0, 4'h0);
      else if ($urandom_range(0, 9) == 0) step(1'b0, 32'h0, 32'h0, 4'h0);
      else step(1'b1, BASE + {29'h0, 3'($urandom_range(0, 7))}, 32'h0, 4'h0);
    end
    idle_cycles(250);
    chk("final_busy", {31'h0, busy}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
